// File: rtl/varredura_colunas.sv
// varredura_colunas: LED matrix column scanner.
// Scan mode steps a registered one-hot strobe through N_COLS columns, DWELL
// clocks each, pulsing frame_start on entry to column 0. Manual mode decodes
// sel_code (k -> column k-1, 0 -> none).
// Optional macro VARREDURA_BLANK_EN: darkens the first BLANK_CYC clocks of
// every scanned column.
module varredura_colunas #(
    parameter int unsigned N_COLS    = 7,
    parameter int unsigned IDX_W     = 3,
    parameter int unsigned DWELL     = 1000,
    parameter int unsigned BLANK_CYC = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              mode,
    input  logic [IDX_W-1:0]  sel_code,
    output logic [N_COLS-1:0] col_sel,
    output logic [IDX_W-1:0]  col_idx,
    output logic              frame_start
);

    localparam int unsigned PRE_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [PRE_W-1:0]  pre_cnt;
    logic              last_mode;
    logic              entry_pend;

    logic [PRE_W-1:0]  pre_nxt;
    logic [IDX_W-1:0]  idx_nxt;
    logic [N_COLS-1:0] sel_nxt;
    logic              fs_nxt;
    logic              pend_nxt;
    logic              entry;
    logic              term;
    logic              last_col;

    assign term     = (pre_cnt == PRE_W'(DWELL - 1));
    assign last_col = (col_idx == IDX_W'(N_COLS - 1));
    // last_mode follows mode even while frozen, so a manual->scan change seen
    // during en=0 is remembered in entry_pend and applied on the first en=1 edge.
    assign entry    = mode && (!last_mode || entry_pend);

    // Next-state and output decode; precedence is en=0 > mode entry > scan/manual.
    always_comb begin
        pre_nxt  = pre_cnt;
        idx_nxt  = col_idx;
        sel_nxt  = '0;
        fs_nxt   = 1'b0;
        pend_nxt = entry_pend;
        if (!en) begin
            if (!mode)
                pend_nxt = 1'b0;
            else if (!last_mode)
                pend_nxt = 1'b1;
        end else begin
            pend_nxt = 1'b0;
            if (entry) begin
                pre_nxt = '0;
                idx_nxt = '0;
                fs_nxt  = 1'b1;
            end else if (mode) begin
                if (term) begin
                    pre_nxt = '0;
                    idx_nxt = last_col ? '0 : col_idx + 1'b1;
                    fs_nxt  = last_col;
                end else begin
                    pre_nxt = pre_cnt + 1'b1;
                end
            end
            if (mode) begin
                sel_nxt = N_COLS'(1) << idx_nxt;
`ifdef VARREDURA_BLANK_EN
                if (pre_nxt < PRE_W'(BLANK_CYC))
                    sel_nxt = '0;
`endif
            end else if ((sel_code != '0) && (sel_code <= IDX_W'(N_COLS))) begin
                sel_nxt = N_COLS'(1) << (sel_code - 1'b1);
            end
        end
    end

    // State and registered outputs, asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt     <= '0;
            col_idx     <= '0;
            col_sel     <= '0;
            frame_start <= 1'b0;
            last_mode   <= 1'b0;
            entry_pend  <= 1'b0;
        end else begin
            pre_cnt     <= pre_nxt;
            col_idx     <= idx_nxt;
            col_sel     <= sel_nxt;
            frame_start <= fs_nxt;
            last_mode   <= mode;
            entry_pend  <= pend_nxt;
        end
    end

endmodule

// File: tb/tb_varredura_colunas.sv
// tb_varredura_colunas: directed self-checking bench for varredura_colunas
// (N_COLS=7, IDX_W=3, DWELL=4, BLANK_CYC=2).
module tb_varredura_colunas;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [2:0] sel_code;
    logic [6:0] col_sel;
    logic [2:0] col_idx;
    logic       frame_start;

    int n_chk  = 0;
    int n_fail = 0;

    varredura_colunas #(
        .N_COLS(7), .IDX_W(3), .DWELL(4), .BLANK_CYC(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel_code(sel_code),
        .col_sel(col_sel), .col_idx(col_idx), .frame_start(frame_start)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Global time limit
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 ns past it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected scan strobe for column c at prescaler value p
    function automatic logic [6:0] exps(input int c, input int p);
        logic [6:0] one;
        one = 7'd1;
`ifdef VARREDURA_BLANK_EN
        if (p < 2) return 7'd0;
`endif
        return one << c;
    endfunction

    initial begin
        rst_n = 1'b0; en = 1'b0; mode = 1'b0; sel_code = 3'd0;
        #1;
        chk("rst_sel", col_sel, 0);
        chk("rst_idx", col_idx, 0);
        chk("rst_fs",  frame_start, 0);
        tick(); tick();

        // Release into scan: first edge is the manual->scan entry
        rst_n = 1'b1; mode = 1'b1; en = 1'b1;
        tick();
        for (int c = 0; c < 7; c++) begin
            for (int p = 0; p < 4; p++) begin
                chk($sformatf("scan_idx_c%0d_p%0d", c, p), col_idx, c);
                chk($sformatf("scan_sel_c%0d_p%0d", c, p), col_sel, exps(c, p));
                chk($sformatf("scan_fs_c%0d_p%0d", c, p), frame_start, (c == 0 && p == 0));
                tick();
            end
        end
        chk("wrap_idx", col_idx, 0);
        chk("wrap_fs",  frame_start, 1);
        chk("wrap_sel", col_sel, exps(0, 0));

        // Advance to column 3, pre_cnt 1, then freeze for 10 clocks
        for (int i = 0; i < 13; i++) tick();
        chk("pre_frz_idx", col_idx, 3);
        chk("pre_frz_sel", col_sel, exps(3, 1));
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("frz_sel_%0d", i), col_sel, 0);
            chk($sformatf("frz_idx_%0d", i), col_idx, 3);
            chk($sformatf("frz_fs_%0d", i),  frame_start, 0);
        end
        en = 1'b1;
        tick();
        chk("resume_idx_p2", col_idx, 3);
        chk("resume_sel_p2", col_sel, exps(3, 2));
        tick();
        chk("resume_idx_p3", col_idx, 3);
        chk("resume_sel_p3", col_sel, exps(3, 3));
        tick();
        chk("resume_idx_c4", col_idx, 4);
        chk("resume_sel_c4", col_sel, exps(4, 0));
        chk("resume_fs_c4",  frame_start, 0);

        // Mode toggle: two manual clocks at column 4, then re-enter scan
        mode = 1'b0; sel_code = 3'd3;
        tick();
        chk("tog_man_sel1", col_sel, 7'h04);
        chk("tog_man_idx1", col_idx, 4);
        chk("tog_man_fs1",  frame_start, 0);
        tick();
        chk("tog_man_sel2", col_sel, 7'h04);
        chk("tog_man_idx2", col_idx, 4);
        mode = 1'b1;
        tick();
        chk("tog_entry_idx", col_idx, 0);
        chk("tog_entry_fs",  frame_start, 1);
        chk("tog_entry_sel", col_sel, exps(0, 0));
        tick();
        chk("tog_next_fs",  frame_start, 0);
        chk("tog_next_sel", col_sel, exps(0, 1));

        // Manual decode of every code
        mode = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [6:0] one;
            one = 7'd1;
            sel_code = 3'(k);
            tick();
            chk($sformatf("man_sel_k%0d", k), col_sel, (k == 0) ? 7'd0 : (one << (k - 1)));
            chk($sformatf("man_fs_k%0d", k),  frame_start, 0);
            chk($sformatf("man_idx_k%0d", k), col_idx, 0);
        end

        // Mode entry while frozen is applied on the first enabled edge
        en = 1'b0; mode = 1'b1;
        tick();
        chk("frzentry_sel1", col_sel, 0);
        chk("frzentry_fs1",  frame_start, 0);
        tick();
        chk("frzentry_sel2", col_sel, 0);
        en = 1'b1;
        tick();
        chk("frzentry_idx", col_idx, 0);
        chk("frzentry_fs",  frame_start, 1);
        chk("frzentry_sel", col_sel, exps(0, 0));
        tick();
        chk("frzentry_next_fs",  frame_start, 0);
        chk("frzentry_next_sel", col_sel, exps(0, 1));

        // Run to column 5, then assert reset between edges
        for (int i = 0; i < 19; i++) tick();
        chk("pre_rst_idx", col_idx, 5);
        chk("pre_rst_sel", col_sel, exps(5, 0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sel", col_sel, 0);
        chk("async_rst_idx", col_idx, 0);
        chk("async_rst_fs",  frame_start, 0);
        tick();
        chk("held_rst_idx", col_idx, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
